varredura_teclado_4x4: RTL and testbench

//   Scans a 4x4 matrix keypad and debounces it. Emits one 4-bit key code with a single-cycle
//   key_valid strobe per debounced press. Directly feeds decodificador_bcd_to_seg7, connected as
//   key_code->bcd_in and key_valid->key_valid. Rows are driven active-low one at a time.

---
 rtl/teclado_pkg.sv | 39 +++
 rtl/sincronizador_2ff.sv | 24 ++
 rtl/varredura_teclado_4x4.sv | 113 +++++++++++
 tb/tb_varredura_teclado_4x4.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, keymap and
// small helpers for row drive and column priority.
package teclado_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        WAIT_RELEASE,
        REL_DEBOUNCE
    } estado_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Indexed by {row, col}; entry 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,
        4'hC, 4'h9,     4'h8, 4'h7,
        4'hB, 4'h6,     4'h5, 4'h4,
        4'hA, 4'h3,     4'h2, 4'h1
    };

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
        logic [1:0] idx;
        casez (cols)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so idle
// active-low lines read as released.
module sincronizador_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/varredura_teclado_4x4.sv
// 4x4 matrix keypad scanner with press/release debounce; emits one key_valid
// strobe and the mapped key_code per accepted press.
module varredura_teclado_4x4
    import teclado_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    estado_t          estado;
    logic [3:0]       col_s;
    logic [1:0]       row_idx;
    logic [1:0]       col_lat;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] deb_cnt;

    sincronizador_2ff #(.WIDTH(4)) u_sinc_col (
        .clk (clk),
        .rst (rst),
        .d   (col_in),
        .q   (col_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= SCAN;
            row_idx   <= '0;
            col_lat   <= '0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            row_out   <= 4'b1110;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (estado)
                SCAN: begin
                    // Columns are only trusted at dwell end, once the sync pipeline reflects this row.
                    if (dwell_cnt == SCAN_LAST) begin
                        dwell_cnt <= '0;
                        if (col_s == 4'b1111) begin
                            row_idx <= row_idx + 2'd1;
                            row_out <= row_drive(row_idx + 2'd1);
                        end else begin
                            col_lat <= lowest_low_col(col_s);
                            deb_cnt <= '0;
                            estado  <= DEBOUNCE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!col_s[col_lat]) begin
                        deb_cnt <= deb_cnt + 1'b1;
                        if (deb_cnt == DEB_LAST) begin
                            key_valid <= 1'b1;
                            key_code  <= KEYMAP[{row_idx, col_lat}];
                            key_held  <= 1'b1;
                            estado    <= PRESSED;
                        end
                    end else begin
                        row_idx   <= row_idx + 2'd1;
                        row_out   <= row_drive(row_idx + 2'd1);
                        dwell_cnt <= '0;
                        estado    <= SCAN;
                    end
                end
                PRESSED: begin
                    estado <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (col_s == 4'b1111) begin
                        deb_cnt <= '0;
                        estado  <= REL_DEBOUNCE;
                    end
                end
                REL_DEBOUNCE: begin
                    if (col_s == 4'b1111) begin
                        deb_cnt <= deb_cnt + 1'b1;
                        if (deb_cnt == DEB_LAST) begin
                            key_held  <= 1'b0;
                            row_idx   <= row_idx + 2'd1;
                            row_out   <= row_drive(row_idx + 2'd1);
                            dwell_cnt <= '0;
                            estado    <= SCAN;
                        end
                    end else begin
                        estado <= WAIT_RELEASE;
                    end
                end
                default: begin
                    estado <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_varredura_teclado_4x4.sv
// Self-checking bench for varredura_teclado_4x4: keypad matrix model, directed
// scenarios plus randomized presses checked against a key/code reference.
module tb_varredura_teclado_4x4;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0]  teclas [4];
    int unsigned n_checks = 0;
    int unsigned n_erros  = 0;
    int unsigned ciclo    = 0;
    int unsigned strobe_ciclo = 0;
    int unsigned t_press  = 0;
    int unsigned n_exp    = 0;
    bit          mon_on   = 1'b0;
    logic        kv_prev  = 1'b0;
    logic [3:0]  got_q [$];

    varredura_teclado_4x4 #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    // Closed key shorts its column to its row while that row is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (teclas[r][c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            confere("row_one_cold", $countones(~row_out), 1);
            if (key_valid === 1'b1) begin
                confere("kv_not_consecutive", kv_prev, 0);
                got_q.push_back(key_code);
                strobe_ciclo = ciclo;
            end
            kv_prev = key_valid;
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] codigo_esperado(input int unsigned r, input int unsigned c);
        if (c == 3) return 4'(10 + r);
        if (r == 3) return (c == 0) ? 4'hE : ((c == 1) ? 4'h0 : 4'hF);
        return 4'(r * 3 + c + 1);
    endfunction

    task automatic solta_tudo();
        for (int r = 0; r < 4; r++) teclas[r] = 4'b0000;
    endtask

    task automatic pressiona(input int unsigned r, input int unsigned c, input bit bounce);
        if (bounce) begin
            repeat ($urandom_range(1, 3)) begin
                teclas[r][c] = 1'b1;
                tick($urandom_range(1, 3));
                teclas[r][c] = 1'b0;
                tick($urandom_range(1, 3));
            end
        end
        teclas[r][c] = 1'b1;
        t_press = ciclo;
    endtask

    task automatic espera_strobe(input int unsigned n0, output int unsigned lat);
        lat = 0;
        for (int unsigned i = 0; i < 60; i++) begin
            if (got_q.size() > n0) break;
            tick(1);
        end
        lat = strobe_ciclo - t_press;
    endtask

    task automatic mede_queda(output int unsigned n);
        n = 0;
        while (n < 40) begin
            tick(1);
            n++;
            if (key_held === 1'b0) break;
        end
    endtask

    task automatic tecla_completa(input string tag, input int unsigned r, input int unsigned c,
                                  input bit bounce, input int unsigned hold);
        int unsigned lat;
        int unsigned queda;
        logic [3:0]  esp;
        esp = codigo_esperado(r, c);
        pressiona(r, c, bounce);
        espera_strobe(n_exp, lat);
        n_exp++;
        confere({tag, "_strobe_count"}, got_q.size(), n_exp);
        if (got_q.size() == n_exp) confere({tag, "_code"}, got_q[n_exp-1], esp);
        if (!bounce) confere({tag, "_latency_window"}, (lat >= DEB + 3 && lat <= DEB + 3 + 4*SCAN_DIV - 1), 1);
        tick(hold);
        confere({tag, "_held_during"}, key_held, 1);
        confere({tag, "_single_strobe"}, got_q.size(), n_exp);
        solta_tudo();
        mede_queda(queda);
        confere({tag, "_held_fall"}, queda, DEB + 3);
        tick(10);
        confere({tag, "_code_hold"}, key_code, esp);
        confere({tag, "_no_extra"}, got_q.size(), n_exp);
    endtask

    initial begin
        int unsigned queda;
        int unsigned lat;
        int unsigned run;
        bit          found;
        bit          first;
        logic [3:0]  prev;

        solta_tudo();
        rst = 1'b1;
        tick(3);
        confere("reset_row_out", row_out, 4'b1110);
        confere("reset_key_code", key_code, 4'h0);
        confere("reset_key_valid", key_valid, 0);
        confere("reset_key_held", key_held, 0);
        rst = 1'b0;
        mon_on = 1'b1;
        tick(5);

        // '5' held for a long time: one strobe only
        tecla_completa("t1_key5", 1, 1, 1'b0, 40);

        // short closure on '7' must not be accepted, and scanning resumes
        teclas[2][0] = 1'b1;
        tick(5);
        teclas[2][0] = 1'b0;
        tick(30);
        confere("t2_no_strobe", got_q.size(), n_exp);
        prev  = row_out;
        run   = 1;
        first = 1'b1;
        repeat (40) begin
            tick(1);
            if (row_out == prev) begin
                run++;
            end else begin
                if (!first) confere("t2_dwell", run, SCAN_DIV);
                confere("t2_row_next", row_out, {prev[2:0], prev[3]});
                first = 1'b0;
                prev  = row_out;
                run   = 1;
            end
        end

        // '*' then '0'
        tecla_completa("t3_star", 3, 0, 1'b0, 20);
        tick(15);
        confere("t3_code_between", key_code, 4'hE);
        tecla_completa("t3_zero", 3, 1, 1'b0, 20);

        // '2'+'3' together, then 'D' while still held
        teclas[0][1] = 1'b1;
        teclas[0][2] = 1'b1;
        t_press = ciclo;
        espera_strobe(n_exp, lat);
        n_exp++;
        confere("t4_strobe_count", got_q.size(), n_exp);
        if (got_q.size() == n_exp) confere("t4_code_lowest_col", got_q[n_exp-1], 4'h2);
        teclas[3][3] = 1'b1;
        tick(40);
        confere("t4_no_rollover", got_q.size(), n_exp);
        confere("t4_held", key_held, 1);
        solta_tudo();
        tick(30);
        confere("t4_released", key_held, 0);
        confere("t4_no_extra", got_q.size(), n_exp);

        // release bounce on '8'
        teclas[2][1] = 1'b1;
        t_press = ciclo;
        espera_strobe(n_exp, lat);
        n_exp++;
        confere("t5_strobe_count", got_q.size(), n_exp);
        tick(10);
        teclas[2][1] = 1'b0;
        tick(3);
        teclas[2][1] = 1'b1;
        tick(2);
        confere("t5_held_mid_bounce", key_held, 1);
        teclas[2][1] = 1'b0;
        mede_queda(queda);
        confere("t5_held_fall", queda, DEB + 3);
        tick(20);
        confere("t5_no_extra", got_q.size(), n_exp);
        confere("t5_code", key_code, 4'h8);

        // randomized presses with optional contact bounce
        for (int unsigned i = 0; i < 10; i++) begin
            tecla_completa("rnd", $urandom_range(0, 3), $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), $urandom_range(10, 40));
            tick($urandom_range(0, 20));
        end

        // reset in the middle of debouncing '9'
        teclas[2][2] = 1'b1;
        found = 1'b0;
        run   = 0;
        for (int unsigned i = 0; i < 80 && !found; i++) begin
            tick(1);
            if (row_out == 4'b1011) run++;
            else run = 0;
            if (run == 6) found = 1'b1;
        end
        confere("t6_debounce_reached", found, 1);
        confere("t6_no_strobe_yet", got_q.size(), n_exp);
        rst = 1'b1;
        teclas[2][2] = 1'b0;
        tick(1);
        confere("t6_row_out", row_out, 4'b1110);
        confere("t6_key_code", key_code, 4'h0);
        confere("t6_key_valid", key_valid, 0);
        confere("t6_key_held", key_held, 0);
        rst = 1'b0;
        tick(30);
        confere("t6_no_strobe", got_q.size(), n_exp);
        confere("t6_held_after", key_held, 0);
        confere("t6_code_after", key_code, 4'h0);

        confere("total_strobes", got_q.size(), n_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule
